// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor: opcodes, counter
// encodings and the conditional-branch decode.
package branch_target_predictor_pkg;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Only conditional branches are predicted; jumps never are.
  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BGTZ);
  endfunction

endpackage

// File: rtl/branch_target_predictor_btb_table.sv
// Direct-mapped BTB storage: two asynchronous read ports (fetch lookup and
// ID-stage training lookup), one synchronous write port, asynchronous clear.
module btb_table
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output ctr_e             rd_ctr,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [31:0]      up_target,
  output ctr_e             up_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  ctr_e             wr_ctr
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_e             ctr_q    [ENTRIES];

  // Reads see pre-write contents; a same-cycle write lands at the edge.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];
  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];

  // Storage: clear to invalid / weakly-not-taken on reset, write one entry per update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-side branch predictor: same-cycle BTB lookup in IF, prediction carried
// into ID with the IF/ID register, training and mispredict flagging in ID.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 32 - IDX_W - 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        if_id_write,
  input  logic        if_id_flush,
  input  logic        id_taken,
  input  logic [31:0] id_target,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  output logic        id_pred_taken,
  output logic        id_is_branch,
  output logic [31:0] id_pc,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic             rd_valid, up_valid, wr_en, if_branch, hit, up_hit, update;
  logic [TAG_W-1:0] rd_tag, up_tag, if_tag, id_tag;
  logic [IDX_W-1:0] if_idx, id_idx;
  logic [31:0]      rd_target, up_target, wr_target;
  ctr_e             rd_ctr, up_ctr, wr_ctr;

  logic        id_pred_taken_q, id_pred_taken_d;
  logic        id_is_branch_q, id_is_branch_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic unused_bits;
  assign unused_bits = ^{if_inst[25:0], if_pc[1:0], id_pc_q[1:0]};

  assign if_idx    = if_pc[IDX_W+1:2];
  assign if_tag    = if_pc[31:IDX_W+2];
  assign id_idx    = id_pc_q[IDX_W+1:2];
  assign id_tag    = id_pc_q[31:IDX_W+2];
  assign if_branch = is_branch(if_inst[31:26]);

  btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_idx    (if_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .up_idx    (id_idx),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_ctr    (up_ctr),
    .wr_en     (wr_en),
    .wr_idx    (id_idx),
    .wr_tag    (id_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // IF lookup: predict taken only for a tag-matching conditional branch with ctr MSB set.
  assign hit        = rd_valid && (rd_tag == if_tag) && if_branch;
  assign pred_taken = hit && rd_ctr[1];
  assign pred_pc    = pred_taken ? rd_target : (if_pc + 32'd4);

  // A branch trains once, on the edge it leaves ID; a stall holds it in place.
  assign update     = id_is_branch_q && if_id_write;
  assign mispredict = id_is_branch_q && (id_pred_taken_q != id_taken);
  assign up_hit     = up_valid && (up_tag == id_tag);

  // Training write: saturating counter step on a hit, weakly-taken allocate on a taken miss.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = up_target;
    wr_ctr    = up_ctr;
    if (update) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (id_taken) begin
          wr_target = id_target;
          wr_ctr    = (up_ctr == ST) ? ST : ctr_e'(up_ctr + 2'd1);
        end else begin
          wr_ctr    = (up_ctr == SNT) ? SNT : ctr_e'(up_ctr - 2'd1);
        end
      end else if (id_taken) begin
        wr_en     = 1'b1;
        wr_target = id_target;
        wr_ctr    = WT;
      end
    end
  end

  // IF/ID next state: flush clears the branch info but keeps the PC; write=0 holds.
  always_comb begin
    id_pred_taken_d = id_pred_taken_q;
    id_is_branch_d  = id_is_branch_q;
    id_pc_d         = id_pc_q;
    if (if_id_flush) begin
      id_pred_taken_d = 1'b0;
      id_is_branch_d  = 1'b0;
    end else if (if_id_write) begin
      id_pred_taken_d = pred_taken;
      id_is_branch_d  = if_branch;
      id_pc_d         = if_pc;
    end
  end

  // Statistics next state: saturating counts of trained and mispredicted branches.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Pipeline and statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_pred_taken_q <= 1'b0;
      id_is_branch_q  <= 1'b0;
      id_pc_q         <= '0;
      branch_cnt_q    <= '0;
      mispred_cnt_q   <= '0;
    end else begin
      id_pred_taken_q <= id_pred_taken_d;
      id_is_branch_q  <= id_is_branch_d;
      id_pc_q         <= id_pc_d;
      branch_cnt_q    <= branch_cnt_d;
      mispred_cnt_q   <= mispred_cnt_d;
    end
  end

  assign id_pred_taken = id_pred_taken_q;
  assign id_is_branch  = id_is_branch_q;
  assign id_pc         = id_pc_q;
  assign branch_cnt    = branch_cnt_q;
  assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;

  localparam logic [31:0] BEQ = 32'h1000_0000;
  localparam logic [31:0] BNE = 32'h1400_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock, reset_n;
  logic [31:0] if_pc, if_inst, id_target, pred_pc, id_pc, branch_cnt, mispred_cnt;
  logic        if_id_write, if_id_flush, id_taken;
  logic        pred_taken, id_pred_taken, id_is_branch, mispredict;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  branch_target_predictor dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_taken      (id_taken),
    .id_target     (id_target),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .id_pred_taken (id_pred_taken),
    .id_is_branch  (id_is_branch),
    .id_pc         (id_pc),
    .mispredict    (mispredict),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive fetch and ID resolution inputs, then let combinational outputs settle.
  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic taken, input logic [31:0] target);
    if_pc     = pc;
    if_inst   = inst;
    id_taken  = taken;
    id_target = target;
    #1;
  endtask

  task automatic check_pred(input string tag, input logic t, input logic [31:0] pc);
    check_eq({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
    check_eq({tag, "_pc"}, pred_pc, pc);
  endtask

  task automatic check_cnt(input string tag, input int b, input int m);
    check_eq({tag, "_branch_cnt"}, branch_cnt, b);
    check_eq({tag, "_mispred_cnt"}, mispred_cnt, m);
  endtask

  task automatic check_id(input string tag, input logic br, input logic pt, input logic [31:0] pc);
    check_eq({tag, "_id_is_branch"}, {31'd0, id_is_branch}, {31'd0, br});
    check_eq({tag, "_id_pred_taken"}, {31'd0, id_pred_taken}, {31'd0, pt});
    check_eq({tag, "_id_pc"}, id_pc, pc);
  endtask

  initial begin
    reset_n = 1'b0; if_id_write = 1'b1; if_id_flush = 1'b0;
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    #1;
    check_pred("rst", 1'b0, 32'h0040_0014);
    check_id("rst", 1'b0, 1'b0, 32'h0);
    check_cnt("rst", 0, 0);
    tick(); tick();
    reset_n = 1'b1;

    // Step 1: cold fetch of beq predicts fall-through.
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_pred("cold", 1'b0, 32'h0040_0014);
    tick();
    // Step 2: resolve taken -> mispredict, allocate weakly taken.
    drive(32'h0040_0014, NOP, 1'b1, 32'h0040_0100);
    check_id("s1", 1'b1, 1'b0, 32'h0040_0010);
    check_eq("s2_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    drive(32'h0040_0010, NOP, 1'b0, 32'h0);
    check_cnt("s2", 1, 1);
    check_pred("s2_nonbranch", 1'b0, 32'h0040_0014);
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_pred("s2_trained", 1'b1, 32'h0040_0100);
    tick();
    // Step 3: not-taken twice, lookup in the update cycle sees old ctr (10).
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_eq("s3a_mispredict", {31'd0, mispredict}, 32'd1);
    check_pred("s3a_collide", 1'b1, 32'h0040_0100);
    tick();
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_pred("s3b_ctr01", 1'b0, 32'h0040_0014);
    tick();
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_cnt("s3c", 3, 3);
    check_eq("s3c_mispredict", {31'd0, mispredict}, 32'd0);
    check_pred("s3c_ctr00", 1'b0, 32'h0040_0014);
    tick();
    // ctr saturated at 00: a wrap would now predict taken.
    drive(32'h0040_0010, BEQ, 1'b1, 32'h0040_0100);
    check_cnt("s3d", 4, 3);
    check_pred("s3d_sat00", 1'b0, 32'h0040_0014);
    tick();
    drive(32'h0040_0014, NOP, 1'b1, 32'h0040_0100);
    check_pred("s3e_ctr01", 1'b0, 32'h0040_0018);
    tick();
    // Step 4: entry back at 10; alias bne at 0x50 shares idx 4, different tag.
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_cnt("s4a", 6, 5);
    check_pred("s4a_retrained", 1'b1, 32'h0040_0100);
    drive(32'h0040_0050, BNE, 1'b0, 32'h0);
    check_pred("s4a_alias", 1'b0, 32'h0040_0054);
    tick();
    drive(32'h0040_0054, NOP, 1'b1, 32'h0040_0200);
    check_id("s4b", 1'b1, 1'b0, 32'h0040_0050);
    check_cnt("s4b", 6, 5);
    tick();
    drive(32'h0040_0010, BEQ, 1'b0, 32'h0);
    check_cnt("s4c", 7, 6);
    check_pred("s4c_evicted", 1'b0, 32'h0040_0014);
    drive(32'h0040_0050, BNE, 1'b0, 32'h0);
    check_pred("s4c_replaced", 1'b1, 32'h0040_0200);
    tick();
    // Step 5: stall the bne in ID for 3 cycles; it trains once on release.
    if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0040_0050);
    for (int i = 0; i < 3; i++) begin
      drive(32'h0040_0200, NOP, 1'b1, 32'h0040_0200);
      check_id("s5_stall", 1'b1, 1'b1, exp_q.pop_front());
      check_cnt("s5_stall", 7, 6);
      tick();
    end
    if_id_write = 1'b1;
    drive(32'h0040_0200, NOP, 1'b1, 32'h0040_0200);
    check_eq("s5_rel_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    drive(32'h0040_0050, BNE, 1'b0, 32'h0);
    check_cnt("s5_rel", 8, 6);
    check_pred("s5_ctr11", 1'b1, 32'h0040_0200);
    tick();
    drive(32'h0040_0200, NOP, 1'b1, 32'h0040_0200);
    tick();
    // ctr saturated at 11; one not-taken leaves it at 10 (still taken).
    drive(32'h0040_0050, BNE, 1'b0, 32'h0);
    tick();
    drive(32'h0040_0054, NOP, 1'b0, 32'h0);
    check_eq("s5_nt_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    drive(32'h0040_0050, BNE, 1'b1, 32'h0);
    check_cnt("s5_sat", 10, 7);
    check_pred("s5_sat11", 1'b1, 32'h0040_0200);
    if_id_flush = 1'b1;
    tick();
    if_id_flush = 1'b0;
    drive(32'h0040_0058, NOP, 1'b1, 32'h0);
    check_id("s5_flush", 1'b0, 1'b0, 32'h0040_0054);
    check_eq("s5_flush_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    check_cnt("s5_flush", 10, 7);

    // Step 6: asynchronous reset between edges clears everything at once.
    drive(32'h0040_0050, BNE, 1'b0, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    check_cnt("s6_rst", 0, 0);
    check_id("s6_rst", 1'b0, 1'b0, 32'h0);
    check_pred("s6_rst", 1'b0, 32'h0040_0054);
    tick();
    reset_n = 1'b1;
    drive(32'h0040_0050, BNE, 1'b0, 32'h0);
    check_pred("s6_after", 1'b0, 32'h0040_0054);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Fetch-side predictor feeding the IF-stage next-PC selection.
- Looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and produces a predicted next PC and a taken flag in the same cycle.
- Carries the prediction into ID alongside the IF/ID register.
- Takes the ID-stage resolution (taken, target) to train the table, and flags mispredicts so the core can flush IF/ID.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two.
- IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2].
- TAG_W, 26, 32-IDX_W-2; tag = pc[31:IDX_W+2].

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- if_pc  in  32  current fetch PC
- if_inst  in  32  instruction fetched at if_pc
- if_id_write  in  1  IF/ID advance enable; 0 = hazard stall
- if_id_flush  in  1  IF/ID flush; takes priority over if_id_write
- id_taken  in  1  resolved branch outcome in ID (PCSrc)
- id_target  in  32  resolved branch target in ID
- pred_taken  out  1  IF prediction; combinational
- pred_pc  out  32  predicted target when pred_taken=1; otherwise if_pc+4
- id_pred_taken  out  1  prediction carried into ID; registered
- id_is_branch  out  1  ID holds a conditional branch; registered
- id_pc  out  32  PC of the instruction in ID; registered
- mispredict  out  1  id_is_branch & (id_pred_taken != id_taken); combinational
- branch_cnt  out  32  resolved branches; registered
- mispred_cnt  out  32  mispredicted branches; registered

Behaviour:
- Branch decode on if_inst[31:26]: beq 000100, bne 000101, bgtz 000111. All other opcodes are not branches. j/jr are never predicted.
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Lookup (combinational, IF):
  - hit = valid[idx] & (tag[idx] == if_pc tag) & is_branch(if_inst).
  - pred_taken = hit & ctr[idx][1].
  - pred_pc = pred_taken ? target[idx] : if_pc+4 (32-bit wrap).
- ID pipeline register (posedge clock, or reset):
  - reset_n=0: id_pred_taken=0, id_is_branch=0, id_pc=0.
  - if_id_flush=1: id_pred_taken=0, id_is_branch=0, id_pc unchanged.
  - else if if_id_write=1: load pred_taken, is_branch(if_inst), if_pc.
  - else: hold.
- Update condition: id_is_branch & if_id_write & !if_id_flush_from_other_source. Concretely, update on the posedge where id_is_branch=1 and if_id_write=1. A stalled branch in ID trains exactly once, on the cycle it leaves ID.
  - Update index and tag come from id_pc.
  - Hit on the stored tag: ctr saturating +1 if id_taken, -1 otherwise; bounds 00 and 11. If id_taken, target <= id_target.
  - Miss and id_taken: allocate; valid=1, tag, target=id_target, ctr=10 (weakly taken). Overwrites any prior entry.
  - Miss and !id_taken: no table change.
- Read/write collision on the same index in one cycle: the lookup sees pre-update contents (write takes effect at the edge).
- Counters:
  - On each update edge: branch_cnt += 1; mispred_cnt += 1 if mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- Reset (asynchronous, any time including mid-update):
  - All valid=0, all ctr=01, targets/tags=0, counters=0.
  - pred_taken=0 and pred_pc=if_pc+4 immediately after reset.
- Latency:
  - Prediction: 0 cycles (same cycle as fetch).
  - Training: visible to a lookup on the cycle after the update edge.

Decomposition:
- Shared package:
  - Opcode constants OP_BEQ, OP_BNE, OP_BGTZ.
  - 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - is_branch decode function.
- One natural sub-module: btb_table. Holds storage arrays, asynchronous read port, synchronous write port, and asynchronous clear.

Test Plan:
1. Reset, then fetch beq at 0x0040_0010 -> pred_taken=0, pred_pc=0x0040_0014. Next cycle id_is_branch=1, id_pred_taken=0.
2. Resolve that beq with id_taken=1, id_target=0x0040_0100 -> mispredict=1, mispred_cnt=1, branch_cnt=1. Refetch 0x0040_0010: pred_taken=1, pred_pc=0x0040_0100.
3. Resolve the same branch not-taken twice -> ctr 10->01->00. The third fetch predicts not-taken; the counter saturates at 00 on a further not-taken.
4. Alias: after step 2, fetch a bne at 0x0040_0050 (same idx, different tag) -> pred_taken=0. Resolve it taken to 0x0040_0200: entry replaced, and a lookup at 0x0040_0010 now misses.
5. Hold if_id_write=0 for 3 cycles with a branch in ID -> id_* outputs hold, branch_cnt increments by exactly 1 when released. if_id_flush=1 -> id_is_branch=0, no update.
6. Assert reset_n=0 mid-cycle after training -> outputs clear without a clock edge. Next fetch of the trained PC predicts not-taken.
